ws2812b_rx: RTL

Decodes a single-wire WS2812B stream back into 24-bit GRB pixel words. It is the receiving end of the stream generated by the ws2812b output modules. It serves as a loopback checker on a spare pmod input, and as the front end for chaining boards. It recovers frame boundaries from the reset gap and reports pixel index, per-frame pixel count and protocol errors.

---
 rtl/ws2812b_pkg.sv | 27 ++
 rtl/ws2812b_pulse_meter.sv | 72 +++++++
 rtl/ws2812b_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver FSM states and default timing at FCLK.
package ws2812b_pkg;

   typedef enum logic [1:0] {
      StSync,
      StIdle,
      StHigh,
      StLow
   } ws_state_e;

   localparam int unsigned FclkHz = 17_000_000;

   // Transmit-side pulse widths, in clk cycles.
   localparam int unsigned CyclesShort = 6;
   localparam int unsigned CyclesLong  = 13;

   // Receive-side decoding limits, in clk cycles.
   localparam int unsigned CyclesMinHigh = 2;
   localparam int unsigned CyclesThresh  = (CyclesShort + CyclesLong + 1) / 2;
   localparam int unsigned CyclesMaxHigh = 40;
   localparam int unsigned CyclesRet     = FclkHz / 20_000;  // 50 us reset gap

   localparam int unsigned MaxLeds = 121;

   localparam int unsigned PixelBits = 24;

endpackage

// File: rtl/ws2812b_pulse_meter.sv
// Synchronizes the serial line, detects edges and measures high/low run lengths.
module ws2812b_pulse_meter #(
   parameter int unsigned CYCLES_MAX_HIGH = 40,
   parameter int unsigned CYCLES_RET      = 850,
   localparam int unsigned HW = $clog2(CYCLES_MAX_HIGH + 2),
   localparam int unsigned LW = $clog2(CYCLES_RET + 1)
) (
   input  logic          clk_i,
   input  logic          resetn_i,
   input  logic          data_i,
   output logic          rise_o,
   output logic          fall_o,
   output logic [HW-1:0] hcnt_o,
   output logic          gap_reached_o
);

   localparam logic [HW-1:0] HSat = HW'(CYCLES_MAX_HIGH + 1);
   localparam logic [LW-1:0] LSat = LW'(CYCLES_RET);

   logic          sync1_q, sync2_q, prev_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [LW-1:0] lcnt_q, lcnt_d;

   assign rise_o        = sync2_q & ~prev_q;
   assign fall_o        = ~sync2_q & prev_q;
   assign hcnt_o        = hcnt_q;
   assign gap_reached_o = (lcnt_q == LSat);

   // Two-flop synchronizer followed by the edge-detect register.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= data_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // hcnt holds the number of high cycles of the current/last pulse; it restarts at 1
   // on the rising cycle so it equals the pulse width when the fall is seen.
   // lcnt counts consecutive low cycles and clears on any high cycle.
   always_comb begin
      hcnt_d = hcnt_q;
      if (rise_o) begin
         hcnt_d = HW'(1);
      end else if (sync2_q && (hcnt_q != HSat)) begin
         hcnt_d = hcnt_q + HW'(1);
      end

      lcnt_d = lcnt_q;
      if (sync2_q) begin
         lcnt_d = '0;
      end else if (lcnt_q != LSat) begin
         lcnt_d = lcnt_q + LW'(1);
      end
   end

   // Run-length counter registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         hcnt_q <= '0;
         lcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         lcnt_q <= lcnt_d;
      end
   end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes pulses into 24-bit GRB words and tracks frame boundaries.
module ws2812b_rx
   import ws2812b_pkg::*;
#(
   parameter int unsigned CYCLES_MIN_HIGH = CyclesMinHigh,
   parameter int unsigned CYCLES_THRESH   = CyclesThresh,
   parameter int unsigned CYCLES_MAX_HIGH = CyclesMaxHigh,
   parameter int unsigned CYCLES_RET      = CyclesRet,
   parameter int unsigned MAX_LEDS        = MaxLeds,
   localparam int unsigned IW = $clog2(MAX_LEDS + 1)
) (
   input  logic          clk_i,
   input  logic          resetn_i,
   input  logic          ws2812b_data_i,
   output logic [23:0]   pixel_o,
   output logic          pixel_valid_o,
   output logic [IW-1:0] pixel_index_o,
   output logic          frame_done_o,
   output logic [IW-1:0] frame_pixels_o,
   output logic          error_o,
   output logic          busy_o
);

   localparam int unsigned HW = $clog2(CYCLES_MAX_HIGH + 2);
   localparam logic [HW-1:0] HMin    = HW'(CYCLES_MIN_HIGH);
   localparam logic [HW-1:0] HThresh = HW'(CYCLES_THRESH);
   localparam logic [HW-1:0] HMax    = HW'(CYCLES_MAX_HIGH);
   localparam logic [IW-1:0] PixMax  = IW'(MAX_LEDS);
   localparam logic [4:0]    LastBit = 5'(PixelBits - 1);

   logic          rise, fall, gap_reached;
   logic [HW-1:0] hcnt;

   ws_state_e     state_q, state_d;
   logic [23:0]   shift_q, shift_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] pix_cnt_q, pix_cnt_d;
   logic [23:0]   pixel_q, pixel_d;
   logic          pixel_valid_q, pixel_valid_d;
   logic [IW-1:0] pixel_index_q, pixel_index_d;
   logic          frame_done_q, frame_done_d;
   logic [IW-1:0] frame_pixels_q, frame_pixels_d;
   logic          error_q, error_d;
   logic          busy_q, busy_d;

   logic          bit_val, bit_bad;
   logic [23:0]   word;

   ws2812b_pulse_meter #(
      .CYCLES_MAX_HIGH (CYCLES_MAX_HIGH),
      .CYCLES_RET      (CYCLES_RET)
   ) u_meter (
      .clk_i         (clk_i),
      .resetn_i      (resetn_i),
      .data_i        (ws2812b_data_i),
      .rise_o        (rise),
      .fall_o        (fall),
      .hcnt_o        (hcnt),
      .gap_reached_o (gap_reached)
   );

   assign bit_val = (hcnt >= HThresh);
   assign bit_bad = (hcnt < HMin) || (hcnt > HMax);
   assign word    = {shift_q[22:0], bit_val};

   // Next-state logic: FSM transitions, bit shifting, pixel and frame bookkeeping.
   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      pix_cnt_d      = pix_cnt_q;
      pixel_d        = pixel_q;
      pixel_valid_d  = 1'b0;
      pixel_index_d  = pixel_index_q;
      frame_done_d   = 1'b0;
      frame_pixels_d = frame_pixels_q;
      error_d        = 1'b0;
      busy_d         = busy_q;

      unique case (state_q)
         // Wait for a full reset gap so decoding never starts mid-frame.
         StSync: begin
            if (gap_reached) begin
               state_d = StIdle;
            end
         end

         StIdle: begin
            if (rise) begin
               state_d = StHigh;
               busy_d  = 1'b1;
            end
         end

         StHigh: begin
            if (fall) begin
               state_d = StLow;
               if (bit_bad) begin
                  error_d = 1'b1;
               end else if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  if (pix_cnt_q == PixMax) begin
                     error_d = 1'b1;
                  end else begin
                     pixel_d       = word;
                     pixel_valid_d = 1'b1;
                     pixel_index_d = pix_cnt_q;
                     pix_cnt_d     = pix_cnt_q + IW'(1);
                  end
               end else begin
                  shift_d   = word;
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end

         // A rise coinciding with the gap closes this frame and opens the next one.
         StLow: begin
            if (gap_reached) begin
               frame_done_d   = 1'b1;
               frame_pixels_d = pix_cnt_q;
               error_d        = (bit_cnt_q != 5'd0);
               pix_cnt_d      = '0;
               bit_cnt_d      = '0;
               shift_d        = '0;
               busy_d         = rise;
               state_d        = rise ? StHigh : StIdle;
            end else if (rise) begin
               state_d = StHigh;
            end
         end

         default: state_d = StSync;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q        <= StSync;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         pix_cnt_q      <= '0;
         pixel_q        <= '0;
         pixel_valid_q  <= 1'b0;
         pixel_index_q  <= '0;
         frame_done_q   <= 1'b0;
         frame_pixels_q <= '0;
         error_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         pix_cnt_q      <= pix_cnt_d;
         pixel_q        <= pixel_d;
         pixel_valid_q  <= pixel_valid_d;
         pixel_index_q  <= pixel_index_d;
         frame_done_q   <= frame_done_d;
         frame_pixels_q <= frame_pixels_d;
         error_q        <= error_d;
         busy_q         <= busy_d;
      end
   end

   assign pixel_o        = pixel_q;
   assign pixel_valid_o  = pixel_valid_q;
   assign pixel_index_o  = pixel_index_q;
   assign frame_done_o   = frame_done_q;
   assign frame_pixels_o = frame_pixels_q;
   assign error_o        = error_q;
   assign busy_o         = busy_q;

endmodule
